// File: rtl/iod_delay_tap_ctrl.sv
// Delay-line tap sequencer for a bank of IOD lanes.
// Takes one load / set / increment / decrement request at a time, paces the
// per-lane LOAD / MOVE / DIRECTION strobes and tracks the tap of every lane.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request (REQ_READY=1 except right after reset)
// CHECK | range-check the latched request, compute step count/direction
// LOAD  | DELAY_LINE_LOAD strobe on the addressed lane, tap := LOAD_TAP
// DIR   | DELAY_LINE_DIRECTION settles one cycle ahead of the first MOVE
// MOVE  | DELAY_LINE_MOVE strobe, tracked tap steps by one
// GAP   | idle spacing after LOAD/MOVE; last cycle samples OUT_OF_RANGE
// FIN   | DONE pulse (qualified by ERR), back to IDLE
module iod_delay_tap_ctrl #(
  parameter int NUM_LANES = 16,
  parameter int TAP_W     = 8,
  parameter int MAX_TAP   = 255,
  parameter int LOAD_TAP  = 1,
  parameter int MOVE_GAP  = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [LANE_W-1:0]          REQ_LANE,
  input  logic [1:0]                 REQ_MODE,
  input  logic [TAP_W-1:0]           REQ_TAP,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic                       DONE,
  output logic                       ERR,
  output logic [NUM_LANES*TAP_W-1:0] TAP_STATE
);

  localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MOVE_GAP - 1);
  localparam logic [TAP_W:0]   MAX_EXT  = (TAP_W + 1)'(MAX_TAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_DIR,
    S_MOVE,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state;
  logic [LANE_W-1:0] lane_q;
  logic [1:0]        mode_q;
  logic [TAP_W-1:0]  req_tap_q;
  logic [TAP_W-1:0]  steps_q;
  logic [GAP_W-1:0]  gap_q;
  logic [TAP_W-1:0]  tap_q [NUM_LANES];

  logic              lane_ok;
  logic [TAP_W-1:0]  cur;
  logic [TAP_W:0]    target;
  logic              reject;
  logic              dir_up;
  logic [TAP_W-1:0]  n_steps;
  logic [TAP_W-1:0]  tap_stepped;

  // Flatten the per-lane tap registers onto the status bus.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap_out
    assign TAP_STATE[g*TAP_W +: TAP_W] = tap_q[g];
  end

  // Range check and step/direction computation for the latched request;
  // target is one bit wider so increments past the top cannot wrap.
  always_comb begin
    lane_ok = (32'(lane_q) < NUM_LANES);
    cur     = '0;
    if (lane_ok) cur = tap_q[lane_q];
    target  = {1'b0, cur};
    reject  = !lane_ok;
    case (mode_q)
      2'b01: begin
        target = {1'b0, req_tap_q};
        if ({1'b0, req_tap_q} > MAX_EXT) reject = 1'b1;
      end
      2'b10: begin
        target = {1'b0, cur} + {1'b0, req_tap_q};
        if (target > MAX_EXT) reject = 1'b1;
      end
      2'b11: begin
        target = {1'b0, cur} - {1'b0, req_tap_q};
        if (req_tap_q > cur) reject = 1'b1;
      end
      default: ;
    endcase
    dir_up      = (target >= {1'b0, cur});
    n_steps     = dir_up ? TAP_W'(target - {1'b0, cur}) : TAP_W'({1'b0, cur} - target);
    tap_stepped = DELAY_LINE_DIRECTION[lane_q] ? cur + 1'b1 : cur - 1'b1;
  end

  // Sequencer: state, registered strobes, DONE/ERR and tap tracking.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state                <= S_IDLE;
      REQ_READY            <= 1'b0;
      DONE                 <= 1'b0;
      ERR                  <= 1'b0;
      DELAY_LINE_LOAD      <= '0;
      DELAY_LINE_MOVE      <= '0;
      DELAY_LINE_DIRECTION <= '0;
      lane_q               <= '0;
      mode_q               <= '0;
      req_tap_q            <= '0;
      steps_q              <= '0;
      gap_q                <= '0;
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= TAP_W'(LOAD_TAP);
    end else begin
      DELAY_LINE_LOAD <= '0;
      DELAY_LINE_MOVE <= '0;
      DONE            <= 1'b0;
      ERR             <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ_READY && REQ_VALID) begin
            lane_q    <= REQ_LANE;
            mode_q    <= REQ_MODE;
            req_tap_q <= REQ_TAP;
            REQ_READY <= 1'b0;
            state     <= S_CHECK;
          end else begin
            REQ_READY <= 1'b1;
          end
        end
        S_CHECK: begin
          if (reject) begin
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            state <= S_FIN;
          end else if (mode_q == 2'b00) begin
            DELAY_LINE_LOAD[lane_q] <= 1'b1;
            tap_q[lane_q]           <= TAP_W'(LOAD_TAP);
            state                   <= S_LOAD;
          end else begin
            DELAY_LINE_DIRECTION[lane_q] <= dir_up;
            steps_q                      <= n_steps;
            state                        <= S_DIR;
          end
        end
        S_LOAD: begin
          gap_q <= GAP_INIT;
          state <= S_GAP;
        end
        S_DIR: begin
          if (steps_q == '0) begin
            DONE  <= 1'b1;
            state <= S_FIN;
          end else begin
            DELAY_LINE_MOVE[lane_q] <= 1'b1;
            tap_q[lane_q]           <= tap_stepped;
            steps_q                 <= steps_q - 1'b1;
            state                   <= S_MOVE;
          end
        end
        S_MOVE: begin
          gap_q <= GAP_INIT;
          state <= S_GAP;
        end
        S_GAP: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end else if (mode_q == 2'b00) begin
            DONE  <= 1'b1;
            state <= S_FIN;
          end else if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
            // Abort keeps the counted tap; the IOD refused to go further.
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            state <= S_FIN;
          end else if (steps_q != '0) begin
            DELAY_LINE_MOVE[lane_q] <= 1'b1;
            tap_q[lane_q]           <= tap_stepped;
            steps_q                 <= steps_q - 1'b1;
            state                   <= S_MOVE;
          end else begin
            DONE  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          REQ_READY <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iod_delay_tap_ctrl.sv
// Directed bench for iod_delay_tap_ctrl with 12 lanes (so an out-of-range
// lane index is representable), 8-bit taps, LOAD_TAP=1, MOVE_GAP=4.
module tb_iod_delay_tap_ctrl;
  localparam int NL = 12;
  localparam int TW = 8;
  localparam int LW = 4;

  logic              FAB_CLK = 1'b0;
  logic              SYNC_RST = 1'b1;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic [LW-1:0]     REQ_LANE = '0;
  logic [1:0]        REQ_MODE = '0;
  logic [TW-1:0]     REQ_TAP = '0;
  logic [NL-1:0]     LOAD_S, MOVE_S, DIR_S;
  logic [NL-1:0]     OOR = '0;
  logic              DONE, ERR;
  logic [NL*TW-1:0]  TAP_STATE;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc = 0;
  int done_cyc, done_err, n_move, load_cyc, other;
  int mv [16];
  logic [NL*TW-1:0] exp_taps;

  iod_delay_tap_ctrl #(
    .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(255), .LOAD_TAP(1), .MOVE_GAP(4)
  ) dut (
    .FAB_CLK                (FAB_CLK),
    .SYNC_RST               (SYNC_RST),
    .REQ_VALID              (REQ_VALID),
    .REQ_READY              (REQ_READY),
    .REQ_LANE               (REQ_LANE),
    .REQ_MODE               (REQ_MODE),
    .REQ_TAP                (REQ_TAP),
    .DELAY_LINE_LOAD        (LOAD_S),
    .DELAY_LINE_MOVE        (MOVE_S),
    .DELAY_LINE_DIRECTION   (DIR_S),
    .DELAY_LINE_OUT_OF_RANGE(OOR),
    .DONE                   (DONE),
    .ERR                    (ERR),
    .TAP_STATE              (TAP_STATE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  // Cycle counter; sampled at negedge it names the current cycle.
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for READY and presents the request.
  task automatic accept(input int lane, input int mode, input int tap);
    int w;
    w = 0;
    while (!REQ_READY && w < 50) begin
      @(negedge FAB_CLK);
      w++;
    end
    check("ready_wait", REQ_READY, 1'b1);
    REQ_VALID = 1'b1;
    REQ_LANE  = LW'(lane);
    REQ_MODE  = 2'(mode);
    REQ_TAP   = TW'(tap);
    acc       = cyc;
  endtask

  // Watches the addressed lane until DONE (or budget), recording relative cycles.
  task automatic collect(input int lane, input int oor_after, input int max_cyc);
    logic [NL-1:0] m;
    m = NL'(1) << lane;
    done_cyc = -1; done_err = 0; n_move = 0; load_cyc = -1; other = 0;
    for (int i = 0; i < 16; i++) mv[i] = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge FAB_CLK);
      REQ_VALID = 1'b0;
      if (|(MOVE_S & m)) begin
        if (n_move < 16) mv[n_move] = cyc - acc;
        n_move++;
      end
      if (|(LOAD_S & m)) load_cyc = cyc - acc;
      if (|((MOVE_S | LOAD_S) & ~m)) other++;
      if (DONE) begin
        done_cyc = cyc - acc;
        done_err = int'(ERR);
        break;
      end
      if (oor_after >= 0 && n_move >= oor_after) OOR = m;
    end
    OOR = '0;
  endtask

  initial begin
    repeat (3) @(negedge FAB_CLK);
    check("rst_ready", REQ_READY, 1'b0);
    check("rst_done", {DONE, ERR}, 2'b00);
    check("rst_strobes", {LOAD_S, MOVE_S, DIR_S}, '0);
    check("rst_taps", TAP_STATE, {NL{8'h01}});
    SYNC_RST = 1'b0;
    @(negedge FAB_CLK);
    check("ready_after_rst", REQ_READY, 1'b1);

    // Load lane 3
    accept(3, 0, 0);
    collect(3, -1, 40);
    check("ld_strobe_cyc", load_cyc, 2);
    check("ld_done_cyc", done_cyc, 7);
    check("ld_err", done_err, 0);
    check("ld_other", other, 0);
    check("ld_tap3", TAP_STATE[3*TW +: TW], 8'd1);

    // Absolute set lane 0: 1 -> 5
    accept(0, 1, 5);
    collect(0, -1, 60);
    check("set_nmove", n_move, 4);
    check("set_mv0", mv[0], 3);
    check("set_mv1", mv[1], 8);
    check("set_mv2", mv[2], 13);
    check("set_mv3", mv[3], 18);
    check("set_done_cyc", done_cyc, 23);
    check("set_err", done_err, 0);
    check("set_dir", DIR_S, 12'h001);
    check("set_tap0", TAP_STATE[0 +: TW], 8'd5);

    // Decrement below zero rejected
    accept(0, 3, 6);
    collect(0, -1, 20);
    check("dec_rej_done", done_cyc, 2);
    check("dec_rej_err", done_err, 1);
    check("dec_rej_move", n_move, 0);
    check("dec_rej_tap0", TAP_STATE[0 +: TW], 8'd5);

    // Increment overflow rejected (5+251=256)
    accept(0, 2, 251);
    collect(0, -1, 20);
    check("inc_rej_done", done_cyc, 2);
    check("inc_rej_err", done_err, 1);

    // Increment to the top (5+250=255)
    accept(0, 2, 250);
    collect(0, -1, 1400);
    check("inc_max_nmove", n_move, 250);
    check("inc_max_done", done_cyc, 1253);
    check("inc_max_err", done_err, 0);
    check("inc_max_tap0", TAP_STATE[0 +: TW], 8'd255);

    // Increment lane 2 by 10, range flag after the 3rd pulse
    accept(2, 2, 10);
    collect(2, 3, 80);
    check("oor_nmove", n_move, 3);
    check("oor_mv2", mv[2], 13);
    check("oor_done", done_cyc, 18);
    check("oor_err", done_err, 1);
    check("oor_tap2", TAP_STATE[2*TW +: TW], 8'd4);
    check("oor_dir", DIR_S, 12'h005);

    // Lane index beyond NUM_LANES
    accept(NL, 0, 0);
    collect(NL, -1, 20);
    check("lane_rej_done", done_cyc, 2);
    check("lane_rej_err", done_err, 1);
    check("lane_rej_strobes", other, 0);

    // Set to current value: zero steps
    accept(0, 1, 255);
    collect(0, -1, 20);
    check("zero_done", done_cyc, 3);
    check("zero_err", done_err, 0);
    check("zero_move", n_move, 0);

    // Decrement lane 0 by 2: 255 -> 253
    accept(0, 3, 2);
    collect(0, -1, 40);
    check("dec_nmove", n_move, 2);
    check("dec_mv1", mv[1], 8);
    check("dec_done", done_cyc, 13);
    check("dec_err", done_err, 0);
    check("dec_dir", DIR_S, 12'h004);
    exp_taps = {NL{8'h01}};
    exp_taps[0 +: TW]    = 8'hfd;
    exp_taps[2*TW +: TW] = 8'h04;
    check("dec_all_taps", TAP_STATE, exp_taps);

    // Reset in the middle of a 10-step move on lane 5
    accept(5, 2, 10);
    n_move = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge FAB_CLK);
      REQ_VALID = 1'b0;
      if (MOVE_S[5]) n_move++;
    end
    check("rst_mid_pre_moves", n_move, 2);
    SYNC_RST = 1'b1;
    @(negedge FAB_CLK);
    check("rst_mid_ready_lo", REQ_READY, 1'b0);
    SYNC_RST = 1'b0;
    @(negedge FAB_CLK);
    check("rst_mid_ready_hi", REQ_READY, 1'b1);
    check("rst_mid_taps", TAP_STATE, {NL{8'h01}});
    check("rst_mid_dir", DIR_S, '0);
    other = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge FAB_CLK);
      if (|MOVE_S || DONE) other++;
    end
    check("rst_mid_quiet", other, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
